// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: sequential shift-and-add unsigned multiplier, one multiplier bit per clock
module seq_shift_add_mult_ha (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module seq_shift_add_mult_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_ci;
    assign o_c = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module seq_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_p
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_mcand, r_acc_hi, r_acc_lo;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_addend, w_sum, w_hi_nxt, w_lo_nxt;
    logic [WIDTH:1]   w_c;
    logic             w_cy;

    assign w_addend = r_acc_lo[0] ? r_mcand : '0;
    assign w_cy     = w_c[WIDTH];
    assign w_hi_nxt = {w_cy, w_sum[WIDTH-1:1]};
    assign w_lo_nxt = {w_sum[0], r_acc_lo[WIDTH-1:1]};

    seq_shift_add_mult_ha u_ha (
        .i_a (r_acc_hi[0]),
        .i_b (w_addend[0]),
        .o_s (w_sum[0]),
        .o_c (w_c[1])
    );

    for (genvar i = 1; i < WIDTH; i++) begin : g_fa
        seq_shift_add_mult_fa u_fa (
            .i_a  (r_acc_hi[i]),
            .i_b  (w_addend[i]),
            .i_ci (w_c[i]),
            .o_s  (w_sum[i]),
            .o_c  (w_c[i+1])
        );
    end

    // next-state decode and state-decoded status outputs
    always_comb begin
        w_next = r_state;
        o_busy = (r_state == RUN);
        o_done = (r_state == FIN);
        unique case (r_state)
            IDLE:    w_next = i_start ? RUN : IDLE;
            RUN:     w_next = (r_cnt == CW'(WIDTH - 1)) ? FIN : RUN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // state, operand latch, accumulate-and-shift datapath, product register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            o_p      <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_start) begin
                r_mcand  <= i_a;
                r_acc_lo <= i_b;
                r_acc_hi <= '0;
                r_cnt    <= '0;
            end
            if (r_state == RUN) begin
                r_acc_hi <= w_hi_nxt;
                r_acc_lo <= w_lo_nxt;
                r_cnt    <= r_cnt + CW'(1);
                if (w_next == FIN) o_p <= {w_hi_nxt, w_lo_nxt};
            end
        end
    end
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult: directed scoreboard bench for 4-bit and 8-bit multipliers
module tb_seq_shift_add_mult;
    logic        clk, rst_n;
    logic        start, busy, done;
    logic [3:0]  a, b;
    logic [7:0]  p;
    logic        start8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  q4[$];
    logic [15:0] q8[$];

    seq_shift_add_mult #(.WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
        .o_busy(busy), .o_done(done), .o_p(p)
    );

    seq_shift_add_mult #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_a(a8), .i_b(b8),
        .o_busy(busy8), .o_done(done8), .o_p(p8)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every DONE pops the oldest expected product
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_chk++;
            assert (q4.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_done4 observed=done expected=no_pending_op");
            end
            if (q4.size() > 0) check("sb_p4", p, q4.pop_front());
            check("busy_done_excl4", busy, 0);
        end
        if (rst_n && done8) begin
            n_chk++;
            assert (q8.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_done8 observed=done expected=no_pending_op");
            end
            if (q8.size() > 0) check("sb_p8", p8, q8.pop_front());
        end
    end

    task automatic op4(input logic [3:0] ai, input logic [3:0] bi, input bit hold, input bit zap);
        logic [7:0] e;
        e = 8'(ai) * 8'(bi);
        a = ai;
        b = bi;
        start = 1;
        q4.push_back(e);
        tick();
        if (!hold) start = 0;
        if (zap) begin
            a = 0;
            b = 0;
        end
        for (int i = 0; i < 4; i++) begin
            check("busy4", busy, 1);
            check("done_low4", done, 0);
            tick();
        end
        check("done4", done, 1);
        check("busy_low4", busy, 0);
        check("p_at_done4", p, e);
        tick();
        check("done_pulse4", done, 0);
        check("p_hold4", p, e);
    endtask

    task automatic op8(input logic [7:0] ai, input logic [7:0] bi);
        logic [15:0] e;
        e = 16'(ai) * 16'(bi);
        a8 = ai;
        b8 = bi;
        start8 = 1;
        q8.push_back(e);
        tick();
        start8 = 0;
        for (int i = 0; i < 8; i++) begin
            check("busy8", busy8, 1);
            tick();
        end
        check("done8", done8, 1);
        check("p_at_done8", p8, e);
        tick();
        check("p_hold8", p8, e);
    endtask

    initial begin
        rst_n = 1;
        start = 0;
        start8 = 0;
        a = 0;
        b = 0;
        a8 = 0;
        b8 = 0;
        #2 rst_n = 0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_p", p, 0);
        check("rst_p8", p8, 0);
        tick();
        tick();
        #2 rst_n = 1;
        tick();
        check("idle_busy", busy, 0);
        op4(13, 11, 0, 0);
        tick();
        check("p_hold_idle", p, 143);
        op4(15, 15, 0, 0);
        op4(0, 9, 0, 0);
        op4(1, 9, 0, 0);
        for (int k = 0; k < 3; k++) op4(3, 5, 1, 0);
        start = 0;
        tick();
        check("held_start_idle", busy, 0);
        op4(7, 6, 0, 1);
        a = 9;
        b = 9;
        start = 1;
        tick();
        start = 0;
        tick();
        #3 rst_n = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_p", p, 0);
        tick();
        tick();
        check("midrst_hold_done", done, 0);
        #2 rst_n = 1;
        tick();
        op4(2, 3, 0, 0);
        op8(255, 255);
        op8(200, 123);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                op4(4'(i), 4'(j), 0, 0);
        tick();
        check("sb_empty4", q4.size(), 0);
        check("sb_empty8", q8.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
